// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin owner of one shared port.
// Requester 0 is instruction fetch and requester 1 is load/store.
// Ownership follows a request/grant/done handshake. The sel output drives
// the address/control steering mux. All outputs are registered.
// Optional feature: define MEM_PORT_ARB_TIMEOUT_EN to build the grant
// timeout counter, the forced-abort path and the err pulse.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req0,
    input  logic req1,
    input  logic done,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic start,
    output logic busy,
    output logic err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    // Catch an out-of-range grant limit when the design is elaborated.
    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be within 2..255");
    end

    state_t r_state;
    state_t w_next;
    logic   w_expire;
    logic   w_release;
    logic   w_entry;
    logic   r_last;
    logic   r_gnt0;
    logic   r_gnt1;
    logic   r_sel;
    logic   r_start;
    logic   r_busy;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // The counter holds 0 on the first grant cycle, so TIMEOUT-1 marks the last allowed cycle.
    assign w_expire = (r_state != S_IDLE) && !done && (r_cnt == CNT_W'(TIMEOUT - 1));

    // Grant-length counter, restarted on every grant entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_expire;
            if (w_entry) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_expire = 1'b0;
    assign err      = 1'b0;
`endif

    // A grant ends on done, or on expiry; done takes priority because expiry requires done low.
    assign w_release = done | w_expire;

    // Arbitration: the owner's own request is masked in its release cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req0 && req1) begin
                    w_next = r_last ? S_OWN0 : S_OWN1;
                end else if (req0) begin
                    w_next = S_OWN0;
                end else if (req1) begin
                    w_next = S_OWN1;
                end
            end
            S_OWN0: begin
                if (w_release) begin
                    w_next = req1 ? S_OWN1 : S_IDLE;
                end
            end
            S_OWN1: begin
                if (w_release) begin
                    w_next = req0 ? S_OWN0 : S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Masking guarantees no self-transition on release, so any change into an OWN state is a fresh grant.
    assign w_entry = (w_next != S_IDLE) && (w_next != r_state);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered outputs and last-grant pointer; sel holds in IDLE so the mux never toggles idly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_sel   <= 1'b0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_gnt0  <= (w_next == S_OWN0);
            r_gnt1  <= (w_next == S_OWN1);
            r_busy  <= (w_next != S_IDLE);
            r_start <= w_entry;
            if (w_next == S_OWN0) begin
                r_sel <= 1'b0;
            end else if (w_next == S_OWN1) begin
                r_sel <= 1'b1;
            end
            if (w_entry) begin
                r_last <= (w_next == S_OWN1);
            end
        end
    end

    assign gnt0  = r_gnt0;
    assign gnt1  = r_gnt1;
    assign sel   = r_sel;
    assign start = r_start;
    assign busy  = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table of directed vectors plus
// hand-written sequences for asynchronous reset and grant timeout.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    logic req0, req1, done;
    logic gnt0, gnt1, sel, start, busy, err;

    int n_checks = 0;
    int n_errors = 0;

    // Packed output view: {gnt0, gnt1, sel, start, busy, err}
    typedef struct packed {
        logic       r0;
        logic       r1;
        logic       d;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs [23];

    mem_port_arbiter #(.TIMEOUT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .done    (done),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sel     (sel),
        .start   (start),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {gnt0, gnt1, sel, start, busy, err};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got {gnt0,gnt1,sel,start,busy,err}=%b expected %b", name, act, expv);
        end
    endtask

    // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic r0, input logic r1, input logic d);
        @(negedge clk);
        req0 = r0;
        req1 = r1;
        done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // idx: {r0, r1, d, {gnt0,gnt1,sel,start,busy,err}}
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 6'b100110}; // single req0: grant cycle 1
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 6'b100010};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 6'b100010};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 6'b000000}; // done on cycle 3 -> idle
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 6'b011110}; // req1 alone
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 6'b001000}; // done on start cycle, sel held
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 6'b001000}; // done in idle ignored
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 6'b100110}; // tie, last=1 -> 0 wins
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 6'b100010};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 6'b011110}; // back-to-back to 1
        vecs[11] = '{1'b1, 1'b1, 1'b0, 6'b011010};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 6'b100110}; // back-to-back to 0
        vecs[13] = '{1'b1, 1'b1, 1'b0, 6'b100010};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 6'b011110};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 6'b001000}; // owner masked, other low -> idle
        vecs[16] = '{1'b0, 1'b0, 1'b0, 6'b001000};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 6'b100110};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 6'b000000};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 6'b011110}; // tie, last=0 -> 1 wins
        vecs[20] = '{1'b1, 1'b1, 1'b1, 6'b100110};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 6'b000000};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 6'b000000};

        reset_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", outs(), 6'b000000);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            step(vecs[i].r0, vecs[i].r1, vecs[i].d);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Asynchronous reset in the middle of a req1 grant.
        step(1'b0, 1'b1, 1'b0);
        check("pre_reset_gnt1", outs(), 6'b011110);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_drop", outs(), 6'b000000);
        @(negedge clk);
        req0 = 1'b1;
        req1 = 1'b1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_tie_gnt0", outs(), 6'b100110);
        step(1'b1, 1'b1, 1'b1);
        check("post_reset_to_gnt1", outs(), 6'b011110);
        step(1'b0, 1'b0, 1'b1);
        check("post_reset_idle", outs(), 6'b001000);

`ifdef MEM_PORT_ARB_TIMEOUT_EN
        // Grant to 0 with no done: aborted after 4 cycles, then req1 takes over.
        step(1'b1, 1'b0, 1'b0);
        check("to_g1", outs(), 6'b100110);
        step(1'b1, 1'b1, 1'b0);
        check("to_g2", outs(), 6'b100010);
        step(1'b1, 1'b1, 1'b0);
        check("to_g3", outs(), 6'b100010);
        step(1'b1, 1'b1, 1'b0);
        check("to_g4", outs(), 6'b100010);
        step(1'b1, 1'b1, 1'b0);
        check("to_abort_err", outs(), 6'b011111);
        step(1'b0, 1'b1, 1'b0);
        check("to_err_one_cycle", outs(), 6'b011010);
        step(1'b0, 1'b1, 1'b1);
        check("to_idle", outs(), 6'b001000);
        // Same again with done on cycle 4: done wins, no err.
        step(1'b1, 1'b0, 1'b0);
        check("tod_g1", outs(), 6'b100110);
        step(1'b1, 1'b1, 1'b0);
        check("tod_g2", outs(), 6'b100010);
        step(1'b1, 1'b1, 1'b0);
        check("tod_g3", outs(), 6'b100010);
        step(1'b1, 1'b1, 1'b0);
        check("tod_g4", outs(), 6'b100010);
        step(1'b1, 1'b1, 1'b1);
        check("tod_done_no_err", outs(), 6'b011110);
        step(1'b0, 1'b1, 1'b1);
        check("tod_idle", outs(), 6'b001000);
        step(1'b0, 1'b0, 1'b0);
        check("tod_idle2", outs(), 6'b001000);
`else
        // Without the timeout feature a grant is held indefinitely.
        step(1'b1, 1'b0, 1'b0);
        check("hold_g1", outs(), 6'b100110);
        for (int c = 2; c <= 120; c++) begin
            step(1'b1, (c > 10) ? 1'b1 : 1'b0, 1'b0);
            check($sformatf("hold_g%0d", c), outs(), 6'b100010);
        end
        step(1'b1, 1'b1, 1'b1);
        check("hold_release_to_gnt1", outs(), 6'b011110);
        step(1'b0, 1'b1, 1'b1);
        check("hold_idle", outs(), 6'b001000);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
